pc_unit: RTL and testbench

//  Parametrised program-counter unit; next generation of the datapath PC. Adds width

---
 rtl/pc_unit_pkg.sv | 16 +
 rtl/pc_unit_if.sv | 28 ++
 rtl/pc_unit_return_stack.sv | 42 ++++
 rtl/pc_unit.sv | 90 +++++++++
 tb/tb_pc_unit.sv | 133 +++++++++++++
 5 files changed

// File: rtl/pc_unit_pkg.sv
// rtl/pc_unit_pkg.sv - op-code definitions shared by the PC unit and its sequencer
package pc_unit_pkg;

    localparam int PC_OP_W = 3;

    // Codes 6 and 7 are reserved and decode as INC.
    typedef enum logic [PC_OP_W-1:0] {
        PC_OP_INC   = 3'd0,
        PC_OP_JMP   = 3'd1,
        PC_OP_BCOND = 3'd2,
        PC_OP_JCOND = 3'd3,
        PC_OP_CALL  = 3'd4,
        PC_OP_RET   = 3'd5
    } pc_op_e;

endpackage

// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - sequencer-to-PC-unit control and status bundle
interface pc_unit_if #(
    parameter int ADDR_W = 10,
    parameter int DISP_W = 8
);
    import pc_unit_pkg::*;

    logic                pc_en;
    logic [PC_OP_W-1:0]  pc_op;
    logic [ADDR_W-1:0]   jump_addr;
    logic [DISP_W-1:0]   disp;
    logic                cond_true;
    logic [ADDR_W-1:0]   pc_out;
    logic [ADDR_W-1:0]   pc_next;
    logic                stack_full;
    logic                stack_empty;
    logic                stack_err;

    modport master (
        output pc_en, pc_op, jump_addr, disp, cond_true,
        input  pc_out, pc_next, stack_full, stack_empty, stack_err
    );

    modport slave (
        input  pc_en, pc_op, jump_addr, disp, cond_true,
        output pc_out, pc_next, stack_full, stack_empty, stack_err
    );
endinterface

// File: rtl/pc_unit_return_stack.sv
// rtl/pc_unit_return_stack.sv - LIFO of return addresses with registered full/empty
module return_stack #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [SP_W-1:0]  sp;
    logic [SP_W-1:0]  sp_dec;

    // dout always shows the top entry so RET can use it in the same cycle.
    assign sp_dec = sp - SP_W'(1);
    assign dout   = mem[sp_dec[IDX_W-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            sp    <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else if (push && !full) begin
            mem[sp[IDX_W-1:0]] <= din;
            sp    <= sp + SP_W'(1);
            full  <= (sp == SP_W'(DEPTH - 1));
            empty <= 1'b0;
        end else if (pop && !empty) begin
            sp    <= sp_dec;
            full  <= 1'b0;
            empty <= (sp == SP_W'(1));
        end
    end
endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with relative/conditional branches and call/return stack
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int                ADDR_W      = 10,
    parameter int                DISP_W      = 8,
    parameter int                STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
    input logic     clk,
    input logic     reset,
    pc_unit_if.slave bus
);
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_rel;
    logic [ADDR_W-1:0] stack_top;
    logic [ADDR_W-1:0] pc_nxt;
    logic              push;
    logic              pop;
    logic              err_set;
    logic              err;
    logic              full;
    logic              empty;

    assign pc_inc = pc + ADDR_W'(1);
    assign pc_rel = pc + ADDR_W'($signed(bus.disp));

    always_comb begin
        pc_nxt  = pc;
        push    = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
        if (reset) begin
            pc_nxt = RESET_ADDR;
        end else if (bus.pc_en) begin
            case (pc_op_e'(bus.pc_op))
                PC_OP_JMP:   pc_nxt = bus.jump_addr;
                PC_OP_BCOND: pc_nxt = bus.cond_true ? pc_rel : pc_inc;
                PC_OP_JCOND: pc_nxt = bus.cond_true ? bus.jump_addr : pc_inc;
                PC_OP_CALL: begin
                    // A faulting CALL/RET leaves the PC where it is.
                    if (full) err_set = 1'b1;
                    else begin
                        push   = 1'b1;
                        pc_nxt = bus.jump_addr;
                    end
                end
                PC_OP_RET: begin
                    if (empty) err_set = 1'b1;
                    else begin
                        pop    = 1'b1;
                        pc_nxt = stack_top;
                    end
                end
                default:     pc_nxt = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc  <= RESET_ADDR;
            err <= 1'b0;
        end else begin
            pc <= pc_nxt;
            if (err_set) err <= 1'b1;
        end
    end

    return_stack #(
        .WIDTH (ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (stack_top),
        .full  (full),
        .empty (empty)
    );

    assign bus.pc_out      = pc;
    assign bus.pc_next     = pc_nxt;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.stack_err   = err;
endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed vector bench for pc_unit with a two-entry return stack
module tb_pc_unit;
    import pc_unit_pkg::*;

    typedef struct {
        logic       rst;
        logic       en;
        logic [2:0] op;
        logic [9:0] ja;
        logic [7:0] disp;
        logic       cond;
        logic [9:0] pc;
        logic       full;
        logic       empty;
        logic       err;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];

    pc_unit_if #(.ADDR_W(10), .DISP_W(8)) bus ();

    pc_unit #(
        .ADDR_W      (10),
        .DISP_W      (8),
        .STACK_DEPTH (2),
        .RESET_ADDR  (10'd0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic en, input logic [2:0] op,
                                input logic [9:0] ja, input logic [7:0] disp, input logic cond,
                                input logic [9:0] pc, input logic full, input logic empty,
                                input logic err);
        vec_t v;
        v.rst = rst; v.en = en; v.op = op; v.ja = ja; v.disp = disp; v.cond = cond;
        v.pc = pc; v.full = full; v.empty = empty; v.err = err;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        reset         = v.rst;
        bus.pc_en     = v.en;
        bus.pc_op     = v.op;
        bus.jump_addr = v.ja;
        bus.disp      = v.disp;
        bus.cond_true = v.cond;
        #1;
        check("pc_next", idx, int'(bus.pc_next), int'(v.pc));
        @(posedge clk);
        #1;
        check("pc_out", idx, int'(bus.pc_out), int'(v.pc));
        check("stack_full", idx, int'(bus.stack_full), int'(v.full));
        check("stack_empty", idx, int'(bus.stack_empty), int'(v.empty));
        check("stack_err", idx, int'(bus.stack_err), int'(v.err));
    endtask

    initial begin
        bus.pc_en = 1'b0; bus.pc_op = '0; bus.jump_addr = '0; bus.disp = '0; bus.cond_true = 1'b0;
        @(posedge clk);
        #1;

        // reset, INC run, stall
        tbl.push_back(mk(1, 1, PC_OP_INC,   0,   0,     0, 0,    0, 1, 0));
        for (int i = 1; i <= 5; i++)
            tbl.push_back(mk(0, 1, PC_OP_INC, 0, 0, 0, 10'(i), 0, 1, 0));
        tbl.push_back(mk(0, 0, PC_OP_JMP,   77,  0,     0, 5,    0, 1, 0));
        tbl.push_back(mk(0, 0, PC_OP_CALL,  77,  0,     1, 5,    0, 1, 0));
        // wrap, relative and conditional branches, reserved ops
        tbl.push_back(mk(0, 1, PC_OP_JMP,   1023, 0,    0, 1023, 0, 1, 0));
        tbl.push_back(mk(0, 1, PC_OP_INC,   0,   0,     0, 0,    0, 1, 0));
        tbl.push_back(mk(0, 1, PC_OP_JMP,   3,   0,     0, 3,    0, 1, 0));
        tbl.push_back(mk(0, 1, PC_OP_BCOND, 0,   8'hFB, 1, 1022, 0, 1, 0));
        tbl.push_back(mk(0, 1, PC_OP_JMP,   3,   0,     0, 3,    0, 1, 0));
        tbl.push_back(mk(0, 1, PC_OP_BCOND, 0,   8'hFB, 0, 4,    0, 1, 0));
        tbl.push_back(mk(0, 1, PC_OP_BCOND, 0,   8'h7F, 1, 131,  0, 1, 0));
        tbl.push_back(mk(0, 1, PC_OP_JCOND, 500, 0,     0, 132,  0, 1, 0));
        tbl.push_back(mk(0, 1, PC_OP_JCOND, 500, 0,     1, 500,  0, 1, 0));
        tbl.push_back(mk(0, 1, 3'd6,        900, 8'h10, 1, 501,  0, 1, 0));
        tbl.push_back(mk(0, 1, 3'd7,        900, 8'h10, 1, 502,  0, 1, 0));
        // nested call/return
        tbl.push_back(mk(0, 1, PC_OP_JMP,   10,  0,     0, 10,   0, 1, 0));
        tbl.push_back(mk(0, 1, PC_OP_CALL,  100, 0,     0, 100,  0, 0, 0));
        tbl.push_back(mk(0, 1, PC_OP_CALL,  200, 0,     0, 200,  1, 0, 0));
        tbl.push_back(mk(0, 1, PC_OP_RET,   0,   0,     0, 101,  0, 0, 0));
        tbl.push_back(mk(0, 1, PC_OP_RET,   0,   0,     0, 11,   0, 1, 0));
        tbl.push_back(mk(0, 1, PC_OP_CALL,  400, 0,     0, 400,  0, 0, 0));
        tbl.push_back(mk(0, 1, PC_OP_RET,   0,   0,     0, 12,   0, 1, 0));
        tbl.push_back(mk(0, 1, PC_OP_CALL,  50,  0,     0, 50,   0, 0, 0));
        tbl.push_back(mk(0, 0, PC_OP_RET,   0,   0,     0, 50,   0, 0, 0));
        tbl.push_back(mk(0, 1, PC_OP_RET,   0,   0,     0, 13,   0, 1, 0));
        // underflow is sticky but does not block later ops
        tbl.push_back(mk(1, 0, PC_OP_INC,   0,   0,     0, 0,    0, 1, 0));
        tbl.push_back(mk(0, 1, PC_OP_RET,   0,   0,     0, 0,    0, 1, 1));
        tbl.push_back(mk(0, 1, PC_OP_JMP,   300, 0,     0, 300,  0, 1, 1));
        tbl.push_back(mk(0, 1, PC_OP_INC,   0,   0,     0, 301,  0, 1, 1));

        foreach (tbl[i]) apply(tbl[i], i);

        // overflow with a two-entry stack, then unwind
        apply(mk(1, 1, PC_OP_CALL, 70, 0, 0, 0,  0, 1, 0), 100);
        apply(mk(0, 1, PC_OP_JMP,  20, 0, 0, 20, 0, 1, 0), 101);
        apply(mk(0, 1, PC_OP_CALL, 30, 0, 0, 30, 0, 0, 0), 102);
        apply(mk(0, 1, PC_OP_CALL, 40, 0, 0, 40, 1, 0, 0), 103);
        apply(mk(0, 1, PC_OP_CALL, 50, 0, 0, 40, 1, 0, 1), 104);
        apply(mk(0, 1, PC_OP_RET,  0,  0, 0, 31, 0, 0, 1), 105);
        apply(mk(0, 1, PC_OP_RET,  0,  0, 0, 21, 0, 1, 1), 106);

        // reset mid-sequence while a CALL is requested and err is set
        apply(mk(0, 1, PC_OP_CALL, 60, 0, 0, 60, 0, 0, 1), 200);
        apply(mk(1, 1, PC_OP_CALL, 70, 0, 0, 0,  0, 1, 0), 201);
        apply(mk(0, 1, PC_OP_INC,  0,  0, 0, 1,  0, 1, 0), 202);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
